an_cmp_filter: RTL

AN_CMP_FILTER -- requirements
Module: an_cmp_filter

---
 rtl/an_cmp_filter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/an_cmp_filter.sv
// an_cmp_filter
//
// Multi-channel comparator front end. Each channel takes an asynchronous
// differential comparator pair (vip/vin), synchronizes both legs, and
// digitally filters the result into a latched per-channel state. The state
// only moves when the synchronized pair disagrees (vip_s != vin_s) and points
// away from the current state for filt_len+1 consecutive enabled cycles.
// When vip_s == vin_s the channel latches its present state.
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   ena       : 1 = filter running, 0 = state/filter frozen (synchronizers run)
//   vip, vin  : asynchronous comparator legs, one bit per channel
//   filt_len  : extra qualifying cycles required before a flip
//   inv       : per-channel output polarity inversion (combinational)
//   clr_cnt   : synchronous clear of all transition counters
//   cnt_sel   : channel whose transition counter drives cnt_out
//   cmp_out   : state XOR inv, per channel
//   rise/fall : registered one-cycle pulses on a state 0->1 / 1->0 change
//   cnt_out   : saturating transition count of channel cnt_sel (0 if out of range)

module an_cmp_filter #(
   parameter int NCH         = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4,
   parameter int CNT_W       = 8,
   localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NCH-1:0]    vip,
   input  logic [NCH-1:0]    vin,
   input  logic [FILT_W-1:0] filt_len,
   input  logic [NCH-1:0]    inv,
   input  logic              clr_cnt,
   input  logic [SEL_W-1:0]  cnt_sel,
   output logic [NCH-1:0]    cmp_out,
   output logic [NCH-1:0]    rise,
   output logic [NCH-1:0]    fall,
   output logic [CNT_W-1:0]  cnt_out
);

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [NCH-1:0]    vip_sync [SYNC_STAGES];
   logic [NCH-1:0]    vin_sync [SYNC_STAGES];
   logic [NCH-1:0]    vip_s;
   logic [NCH-1:0]    vin_s;

   logic [NCH-1:0]    state;
   logic [FILT_W-1:0] fcnt [NCH];
   logic [CNT_W-1:0]  cnt  [NCH];

   logic [NCH-1:0]    qual;
   logic [NCH-1:0]    flip;

   // Synchronizer stages: both legs of every channel, always running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            vip_sync[k] <= '0;
            vin_sync[k] <= '0;
         end
      end else begin
         vip_sync[0] <= vip;
         vin_sync[0] <= vin;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            vip_sync[k] <= vip_sync[k-1];
            vin_sync[k] <= vin_sync[k-1];
         end
      end
   end

   assign vip_s = vip_sync[SYNC_STAGES-1];
   assign vin_s = vin_sync[SYNC_STAGES-1];

   // Qualification and flip decision. A count already above filt_len (after
   // filt_len was lowered mid-count) also flips on the next qualifying edge.
   always_comb begin
      qual = '0;
      flip = '0;
      for (int i = 0; i < NCH; i++) begin
         qual[i] = ena & (vip_s[i] ^ vin_s[i]) & (vip_s[i] != state[i]);
         flip[i] = qual[i] & (fcnt[i] >= filt_len);
      end
   end

   // Filter, state, edge pulses and transition counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= '0;
         rise  <= '0;
         fall  <= '0;
         for (int i = 0; i < NCH; i++) begin
            fcnt[i] <= '0;
            cnt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (ena) begin
               if (flip[i])      fcnt[i] <= '0;
               else if (qual[i]) fcnt[i] <= fcnt[i] + FILT_W'(1);
               else              fcnt[i] <= '0;
            end
            if (flip[i]) state[i] <= vip_s[i];
            // flip is only ever set with ena=1, so pulses are 0 while frozen.
            rise[i] <= flip[i] & vip_s[i];
            fall[i] <= flip[i] & ~vip_s[i];
            if (clr_cnt)      cnt[i] <= '0;
            else if (flip[i]) cnt[i] <= sat_inc(cnt[i]);
         end
      end
   end

   assign cmp_out = state ^ inv;

   // Out-of-range selections match no channel and read as 0.
   always_comb begin
      cnt_out = '0;
      for (int i = 0; i < NCH; i++) begin
         if (cnt_sel == SEL_W'(i)) cnt_out = cnt[i];
      end
   end

endmodule
